// File: rtl/nbit_subtracter.sv
// Registered N-bit ripple-borrow subtracter: {b_out, diff} = a - b - b_in, one cycle after in_valid.
// Optional signed-overflow output enabled by defining NBIT_SUBTRACTER_OVF_EN.
module nbit_subtracter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         b_in,
  output logic         out_valid,
  output logic [N-1:0] diff,
  output logic         b_out
`ifdef NBIT_SUBTRACTER_OVF_EN
  ,
  output logic         ovf
`endif
);

  logic [N:0]   br;
  logic [N-1:0] diff_next;
  logic [N-1:0] diff_reg;
  logic         b_out_reg;
  logic         out_valid_reg;

  assign br[0] = b_in;

  // One full-subtracter cell per bit; the borrow ripples from LSB to MSB.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_cell
      assign diff_next[gi] = a[gi] ^ b[gi] ^ br[gi];
      assign br[gi+1]      = (~a[gi] & b[gi]) | (~(a[gi] ^ b[gi]) & br[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      diff_reg      <= '0;
      b_out_reg     <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= in_valid;
      if (in_valid) begin
        diff_reg  <= diff_next;
        b_out_reg <= br[N];
      end
    end
  end

  assign diff      = diff_reg;
  assign b_out     = b_out_reg;
  assign out_valid = out_valid_reg;

`ifdef NBIT_SUBTRACTER_OVF_EN
  logic ovf_next;
  logic ovf_reg;

  // Operands of differing sign whose result sign departs from the minuend's.
  assign ovf_next = (a[N-1] ^ b[N-1]) & (diff_next[N-1] ^ a[N-1]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if (in_valid) begin
      ovf_reg <= ovf_next;
    end
  end

  assign ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_nbit_subtracter.sv
// Scoreboard bench for nbit_subtracter (N = 4); overflow checks follow NBIT_SUBTRACTER_OVF_EN.
module tb_nbit_subtracter;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         b_in = 1'b0;
  logic         out_valid;
  logic [N-1:0] diff;
  logic         b_out;
`ifdef NBIT_SUBTRACTER_OVF_EN
  logic         ovf;
`endif

  typedef struct packed {
    logic [N-1:0] diff;
    logic         b_out;
    logic         ovf;
  } res_t;

  res_t exp_q[$];
  res_t held;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  nbit_subtracter #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .b_in      (b_in),
    .out_valid (out_valid),
    .diff      (diff),
    .b_out     (b_out)
`ifdef NBIT_SUBTRACTER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference arithmetic done in plain integers, independent of the cell equations.
  function automatic res_t model(input logic [N-1:0] aa, input logic [N-1:0] bb, input logic bi);
    res_t r;
    int   t;
    int   sa;
    int   sb;
    int   st;
    t  = int'(aa) - int'(bb) - int'(bi);
    sa = aa[N-1] ? int'(aa) - (1 << N) : int'(aa);
    sb = bb[N-1] ? int'(bb) - (1 << N) : int'(bb);
    st = sa - sb - int'(bi);
    r.diff  = t[N-1:0];
    r.b_out = (t < 0);
    r.ovf   = (st < -(1 << (N - 1))) || (st > (1 << (N - 1)) - 1);
    return r;
  endfunction

  task automatic cycle(input logic r, input logic v, input logic [N-1:0] aa,
                       input logic [N-1:0] bb, input logic bi, input string tag);
    logic ev;
    rst_n    = r;
    in_valid = v;
    a        = aa;
    b        = bb;
    b_in     = bi;
    ev       = r && v;
    if (ev) exp_q.push_back(model(aa, bb, bi));
    @(posedge clk);
    #1;
    if (!r) begin
      exp_q.delete();
      held = '0;
      check({tag, "_valid"}, 32'(out_valid), 32'd0);
    end else begin
      check({tag, "_valid"}, 32'(out_valid), 32'(ev));
      if (out_valid || ev) begin
        if (exp_q.size() == 0) check({tag, "_spurious"}, 32'd1, 32'd0);
        else held = exp_q.pop_front();
      end
    end
    check({tag, "_diff"}, 32'(diff), 32'(held.diff));
    check({tag, "_b_out"}, 32'(b_out), 32'(held.b_out));
`ifdef NBIT_SUBTRACTER_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(held.ovf));
`endif
    $display("txn %s rst_n=%0d v=%0d a=%0d b=%0d b_in=%0d -> out_valid=%0d diff=%0d b_out=%0d",
             tag, r, v, aa, bb, bi, out_valid, diff, b_out);
  endtask

  initial begin
    held = '0;
    cycle(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, "reset");
    cycle(1'b0, 1'b1, 4'd9, 4'd1, 1'b0, "reset_v");

    cycle(1'b1, 1'b1, 4'd5, 4'd3, 1'b0, "basic");
    cycle(1'b1, 1'b1, 4'd3, 4'd5, 1'b0, "under");
    cycle(1'b1, 1'b1, 4'd0, 4'd0, 1'b1, "under_bin");
    cycle(1'b1, 1'b1, 4'd6, 4'd6, 1'b1, "eq_bin");

    for (int k = 0; k < 520; k++) begin
      logic [8:0] s;
      s = 9'(k);
      cycle(1'b1, 1'b1, s[7:4], s[3:0], s[8], "sweep");
    end

    cycle(1'b1, 1'b1, 4'd9, 4'd2, 1'b0, "hold_load");
    cycle(1'b1, 1'b0, 4'd3, 4'd14, 1'b1, "hold");
    cycle(1'b1, 1'b0, 4'd12, 4'd1, 1'b0, "hold2");

    cycle(1'b1, 1'b1, 4'd6, 4'd1, 1'b0, "pre_rst");
    cycle(1'b0, 1'b1, 4'd10, 4'd3, 1'b0, "mid_rst");
    cycle(1'b1, 1'b1, 4'd12, 4'd5, 1'b1, "post_rst");

    cycle(1'b1, 1'b1, 4'd8, 4'd1, 1'b0, "ovf_neg");
    cycle(1'b1, 1'b1, 4'd7, 4'd15, 1'b0, "ovf_pos");
    cycle(1'b1, 1'b1, 4'd4, 4'd2, 1'b0, "ovf_none");
    cycle(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, "drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
